// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package divider_pkg;

  localparam int WIDTH = 32;

  localparam logic [WIDTH-1:0] DIVZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Magnitude of a two's complement value; -2^31 maps to 32'h8000_0000.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/divider_32bit_divu_step.sv
// One restoring shift/subtract step of an unsigned division.
module divu_step
  import divider_pkg::*;
(
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;

  // quo_i holds the remaining dividend bits; its MSB enters the remainder.
  always_comb begin
    sh     = {rem_i, quo_i[WIDTH-1]};
    diff   = sh - {2'b00, div_i};
    qbit_o = ~diff[WIDTH+1];
    rem_o  = qbit_o ? diff[WIDTH:0] : sh[WIDTH:0];
    quo_o  = {quo_i[WIDTH-2:0], qbit_o};
  end

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle 32-bit signed divider: 32 restoring steps plus a sign-fix cycle.
module divider_32bit
  import divider_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   M,
  output logic [2*WIDTH-1:0] result,
  output logic               diverror,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic               qbit_unused;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  divu_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .div_i  (dvs_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo),
    .qbit_o (qbit_unused)
  );

  always_comb begin
    q_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DIV;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = mag(Q);
          dvs_d   = mag(M);
          dvd_d   = Q;
          qneg_d  = Q[WIDTH-1] ^ M[WIDTH-1];
          rneg_d  = Q[WIDTH-1];
          dz_d    = (M == '0);
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Divide-by-zero bypasses the datapath result entirely.
        res_d   = dz_q ? {dvd_q, DIVZ_QUOT} : {r_fix, q_fix};
        err_d   = dz_q;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign result   = res_q;
  assign diverror = err_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit against a plain-arithmetic reference.
module tb_divider_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] Q;
  logic [31:0] M;
  logic [63:0] result;
  logic        diverror;
  logic        busy;
  logic        done;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  divider_32bit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Q        (Q),
    .M        (M),
    .result   (result),
    .diverror (diverror),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] q, input logic [31:0] m);
    exp_t   e;
    longint a, b, qq, rr;
    if (m == 32'd0) begin
      e.res = {q, 32'hFFFF_FFFF};
      e.err = 1'b1;
    end else begin
      a     = longint'($signed(q));
      b     = longint'($signed(m));
      qq    = a / b;
      rr    = a - qq * b;
      e.res = {rr[31:0], qq[31:0]};
      e.err = 1'b0;
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (prev_done) begin
        checks++;
        errors++;
        $display("FAIL done_width: got 2-cycle pulse expected 1");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("diverror", 64'(diverror), 64'(e.err));
        check("latency", 64'(cyc - e.acc), 64'd33);
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  // mode bit0: scramble Q/M mid-op, bit1: pulse start mid-op
  task automatic issue(input logic [31:0] q, input logic [31:0] m,
                       input int mode);
    exp_t e;
    wait_idle();
    Q     = q;
    M     = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = model(q, m);
    e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    if (mode != 0) begin
      repeat (5) @(negedge clk);
      if (mode[0]) begin
        Q = $urandom;
        M = $urandom;
      end
      if (mode[1]) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] rq, rm;
    rst   = 1'b1;
    start = 1'b1;
    Q     = 32'd9;
    M     = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 64'd0);
    check("rst_diverror", 64'(diverror), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    start = 1'b0;
    rst   = 1'b0;

    issue(-32'sd3, 32'sd2, 0);
    issue(-32'sd7, 32'sd2, 0);
    issue(-32'sd3, -32'sd2, 0);
    issue(-32'sd5, -32'sd2, 0);
    issue(-32'sd7, -32'sd2, 0);
    issue(32'sd7, -32'sd2, 0);
    issue(-32'sd5, 32'd0, 0);
    issue(32'sd8, 32'sd4, 0);
    issue(32'd2000000001, 32'd2000000000, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(32'd0, 32'd5, 0);
    issue(32'h7FFF_FFFF, 32'h8000_0000, 0);
    issue(32'h8000_0000, 32'd1, 0);
    issue(32'd1000, 32'd7, 2);
    issue(-32'sd1000, 32'd13, 1);
    issue(32'd123456789, -32'sd321, 3);

    // The next issue lands on the done cycle of the previous one.
    issue(32'd77, 32'd5, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_done_seen", 64'(done), 64'd1);
    Q     = -32'sd100;
    M     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e     = model(-32'sd100, 32'd9);
      e.acc = cyc;
      sb.push_back(e);
    end
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);

    // Abort an operation with reset partway through.
    wait_idle();
    Q     = -32'sd7;
    M     = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      rq = $urandom;
      rm = $urandom;
      if (n % 3 == 0) rm = 32'($signed(rm) >>> $urandom_range(4, 30));
      if (rm == 32'd0) rm = 32'd3;
      issue(rq, rm, 0);
    end

    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
